// File: rtl/rename_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rename_recovery_ctrl
// Description : Rebuilds the speculative rename map from the committed map
//               after a flush. One CLEAR cycle frees every physical register.
//               WALK_W committed entries per cycle are then copied back into
//               the speculative map and re-marked as allocated. DONE pulses
//               completion and bumps a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module rename_recovery_ctrl #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 48,
  parameter int WALK_W    = 2,
  localparam int AW       = $clog2(ARCH_REGS),
  localparam int PW       = $clog2(PHYS_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_req,
  output logic [WALK_W*AW-1:0] crat_rd_idx,
  input  logic [WALK_W*PW-1:0] crat_rd_phys,
  output logic [WALK_W-1:0]    rat_restore_en,
  output logic [WALK_W*AW-1:0] rat_restore_arch,
  output logic [WALK_W*PW-1:0] rat_restore_phys,
  output logic                 fl_clear,
  output logic [WALK_W-1:0]    fl_mark_en,
  output logic [WALK_W*PW-1:0] fl_mark_phys,
  output logic                 rename_stall,
  output logic                 commit_hold,
  output logic                 busy,
  output logic                 recovery_done,
  output logic [15:0]          recovery_count
);

  // One extra bit so the walk index can never wrap at the top of the map.
  localparam int WI_W = AW + 1;
  localparam logic [WI_W-1:0] LAST_IDX = WI_W'(ARCH_REGS - WALK_W);
  localparam logic [WI_W-1:0] STEP     = WI_W'(WALK_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_WALK  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WI_W-1:0]   walk_idx_q, walk_idx_d;
  logic [15:0]       count_q, count_d;
  logic              in_walk;

  // Next-state logic: a flush in any non-idle state restarts from CLEAR.
  always_comb begin
    state_d    = state_q;
    walk_idx_d = walk_idx_q;
    count_d    = count_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        walk_idx_d = '0;
        state_d    = flush_req ? ST_CLEAR : ST_WALK;
      end
      ST_WALK: begin
        if (flush_req) begin
          state_d    = ST_CLEAR;
          walk_idx_d = '0;
        end else if (walk_idx_q == LAST_IDX) begin
          state_d    = ST_DONE;
          walk_idx_d = '0;
        end else begin
          walk_idx_d = walk_idx_q + STEP;
        end
      end
      ST_DONE: begin
        // The finished pass counts even if a new flush arrives this cycle.
        count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        state_d = flush_req ? ST_CLEAR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, walk pointer and completion counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      walk_idx_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      walk_idx_q <= walk_idx_d;
      count_q    <= count_d;
    end
  end

  // Status outputs decode straight from the state register, so an async
  // reset clears them without waiting for a clock edge.
  assign in_walk        = (state_q == ST_WALK);
  assign busy           = (state_q != ST_IDLE);
  assign commit_hold    = busy;
  assign fl_clear       = (state_q == ST_CLEAR);
  assign recovery_done  = (state_q == ST_DONE);
  assign recovery_count = count_q;
  // Stall in the request cycle itself; forced low while reset is held.
  assign rename_stall   = reset & (flush_req | busy);

  generate
    for (genvar i = 0; i < WALK_W; i++) begin : g_lane
      logic [AW-1:0] lane_arch;
      logic [PW-1:0] lane_phys;
      logic          lane_en;

      assign lane_arch = in_walk ? AW'(walk_idx_q + WI_W'(i)) : '0;
      assign lane_phys = in_walk ? crat_rd_phys[i*PW +: PW] : '0;
      // Arch register 0 is hardwired and never owns a physical register.
      assign lane_en   = in_walk && (lane_arch != '0);

      assign crat_rd_idx[i*AW +: AW]      = lane_arch;
      assign rat_restore_arch[i*AW +: AW] = lane_arch;
      assign rat_restore_phys[i*PW +: PW] = lane_phys;
      assign fl_mark_phys[i*PW +: PW]     = lane_phys;
      assign rat_restore_en[i]            = lane_en;
      assign fl_mark_en[i]                = lane_en;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rename_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_recovery_ctrl
// Description : Directed bench for rename_recovery_ctrl. The committed map is
//               modelled as phys = arch + 16. A vector table covers one basic
//               recovery; hand-written sequences cover re-flush, flush in
//               DONE, async reset mid-walk and counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_recovery_ctrl;

  localparam int WALK_W = 2;
  localparam int AW     = 5;
  localparam int PW     = 6;
  localparam int NWALK  = 16;

  logic                 clk;
  logic                 reset;
  logic                 flush_req;
  logic [WALK_W*AW-1:0] crat_rd_idx;
  logic [WALK_W*PW-1:0] crat_rd_phys;
  logic [WALK_W-1:0]    rat_restore_en;
  logic [WALK_W*AW-1:0] rat_restore_arch;
  logic [WALK_W*PW-1:0] rat_restore_phys;
  logic                 fl_clear;
  logic [WALK_W-1:0]    fl_mark_en;
  logic [WALK_W*PW-1:0] fl_mark_phys;
  logic                 rename_stall;
  logic                 commit_hold;
  logic                 busy;
  logic                 recovery_done;
  logic [15:0]          recovery_count;

  int n_checks = 0;
  int n_fail   = 0;

  rename_recovery_ctrl #(.ARCH_REGS(32), .PHYS_REGS(48), .WALK_W(WALK_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush_req        (flush_req),
    .crat_rd_idx      (crat_rd_idx),
    .crat_rd_phys     (crat_rd_phys),
    .rat_restore_en   (rat_restore_en),
    .rat_restore_arch (rat_restore_arch),
    .rat_restore_phys (rat_restore_phys),
    .fl_clear         (fl_clear),
    .fl_mark_en       (fl_mark_en),
    .fl_mark_phys     (fl_mark_phys),
    .rename_stall     (rename_stall),
    .commit_hold      (commit_hold),
    .busy             (busy),
    .recovery_done    (recovery_done),
    .recovery_count   (recovery_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Committed map model: combinational read, phys = idx + 16.
  always_comb begin
    crat_rd_phys = '0;
    for (int i = 0; i < WALK_W; i++)
      crat_rd_phys[i*PW +: PW] = PW'(crat_rd_idx[i*AW +: AW]) + 6'd16;
  end

  typedef struct {
    bit fl;
    bit clr;
    bit bsy;
    bit stl;
    bit dn;
    int base;
    int cnt;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Compare every output against the expectation for the current cycle.
  // base < 0 means not walking; otherwise lane i restores arch base+i.
  task automatic check_now(input bit e_clr, input bit e_bsy, input bit e_stl,
                           input bit e_dn, input int base, input int e_cnt);
    logic [WALK_W*AW-1:0] e_idx;
    logic [WALK_W*PW-1:0] e_phys;
    logic [WALK_W-1:0]    e_en;
    int a;
    e_idx = '0; e_phys = '0; e_en = '0;
    if (base >= 0) begin
      for (int i = 0; i < WALK_W; i++) begin
        a = base + i;
        e_idx[i*AW +: AW]  = AW'(a);
        e_phys[i*PW +: PW] = PW'(a + 16);
        e_en[i]            = (a != 0);
      end
    end
    chk("crat_rd_idx",      32'(crat_rd_idx),      32'(e_idx));
    chk("rat_restore_arch", 32'(rat_restore_arch), 32'(e_idx));
    chk("rat_restore_phys", 32'(rat_restore_phys), 32'(e_phys));
    chk("fl_mark_phys",     32'(fl_mark_phys),     32'(e_phys));
    chk("rat_restore_en",   32'(rat_restore_en),   32'(e_en));
    chk("fl_mark_en",       32'(fl_mark_en),       32'(e_en));
    chk("clear_mark_excl",  32'(fl_clear & (|fl_mark_en)), 32'd0);
    chk("fl_clear",         32'(fl_clear),         32'(e_clr));
    chk("busy",             32'(busy),             32'(e_bsy));
    chk("commit_hold",      32'(commit_hold),      32'(e_bsy));
    chk("rename_stall",     32'(rename_stall),     32'(e_stl));
    chk("recovery_done",    32'(recovery_done),    32'(e_dn));
    chk("recovery_count",   32'(recovery_count),   32'(e_cnt));
  endtask

  // Drive flush at the falling edge, then check the cycle just after.
  task automatic step(input bit fl, input bit e_clr, input bit e_bsy, input bit e_stl,
                      input bit e_dn, input int base, input int e_cnt);
    @(negedge clk);
    flush_req = fl;
    #1;
    check_now(e_clr, e_bsy, e_stl, e_dn, base, e_cnt);
  endtask

  task automatic walks(input int k0, input int k1, input int cnt);
    for (int k = k0; k <= k1; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2*k, cnt);
  endtask

  // One complete recovery starting from IDLE with count c.
  task automatic full_pass(input int c);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, c);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, c);
    walks(0, NWALK-1, c);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1, c);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, c + 1);
  endtask

  initial begin
    // Basic recovery vectors: request, CLEAR, 16 WALK, DONE, IDLE.
    tbl[0] = '{fl:1, clr:0, bsy:0, stl:1, dn:0, base:-1, cnt:0};
    tbl[1] = '{fl:0, clr:1, bsy:1, stl:1, dn:0, base:-1, cnt:0};
    for (int k = 0; k < NWALK; k++)
      tbl[2+k] = '{fl:0, clr:0, bsy:1, stl:1, dn:0, base:2*k, cnt:0};
    tbl[18] = '{fl:0, clr:0, bsy:1, stl:1, dn:1, base:-1, cnt:0};
    tbl[19] = '{fl:0, clr:0, bsy:0, stl:0, dn:0, base:-1, cnt:1};

    // Reset held: everything quiet, stall low even with a request pending.
    reset = 1'b0;
    flush_req = 1'b0;
    #1;
    check_now(1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    @(negedge clk);
    flush_req = 1'b0;
    reset = 1'b1;

    // Basic recovery from the table.
    for (int r = 0; r < 20; r++)
      step(tbl[r].fl, tbl[r].clr, tbl[r].bsy, tbl[r].stl, tbl[r].dn, tbl[r].base, tbl[r].cnt);

    // Re-flush at WALK cycle 5: restart, single done at end of second pass.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1);
    walks(0, 4, 1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1);
    walks(0, NWALK-1, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 2);

    // Flush during DONE: pass still counts, then a full second pass.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, 2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, 2);
    walks(0, NWALK-1, 2);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, -1, 2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, 3);
    walks(0, NWALK-1, 3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1, 3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 4);

    // Async reset at WALK cycle 8: outputs clear with no clock edge.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, 4);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, 4);
    walks(0, 8, 4);
    #1;
    reset = 1'b0;
    #1;
    check_now(1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    full_pass(0);

    // Saturation: preload the counter just below the limit.
    @(negedge clk);
    force dut.count_q = 16'hFFFE;
    @(negedge clk);
    release dut.count_q;
    #1;
    chk("preload", 32'(recovery_count), 32'hFFFE);
    full_pass(16'hFFFE);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, 16'hFFFF);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, 16'hFFFF);
    walks(0, NWALK-1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
